// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the two-operand entry stage.
package operand_loader_pkg;

    localparam int OPERAND_W = 4;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        SHOW   = 2'd2
    } loader_state_t;

    localparam logic [1:0] LED_WAIT_A = 2'b01;
    localparam logic [1:0] LED_WAIT_B = 2'b10;
    localparam logic [1:0] LED_SHOW   = 2'b00;

    function automatic logic [1:0] state_led_of(input loader_state_t s);
        case (s)
            WAIT_A:  state_led_of = LED_WAIT_A;
            WAIT_B:  state_led_of = LED_WAIT_B;
            default: state_led_of = LED_SHOW;
        endcase
    endfunction

endpackage

// File: rtl/operand_loader_button_debounce.sv
// Button conditioning: 2-flop synchronizer, stability counter, rising-edge pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;
    logic          level, level_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_d <= level;
            // Count only while the input disagrees with the accepted level;
            // any return to agreement (a bounce) restarts the qualification.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign btn_level = level;
    assign btn_pulse = level & ~level_d;

endmodule

// File: rtl/operand_loader.sv
// Operand entry FSM: captures A then B from shared switches on debounced load presses.
// Optional WAIT_B timeout enabled by defining OPERAND_TIMEOUT_EN.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] sw,
    input  logic                 btn_load,
    input  logic                 btn_clr,
    output logic [OPERAND_W-1:0] A,
    output logic [OPERAND_W-1:0] B,
    output logic                 valid,
    output logic [1:0]           state_led
);
    logic load_p, clr_p, load_lvl, clr_lvl;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
        .clk(clk), .rst(rst), .btn_raw(btn_load), .btn_level(load_lvl), .btn_pulse(load_p)
    );
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
        .clk(clk), .rst(rst), .btn_raw(btn_clr), .btn_level(clr_lvl), .btn_pulse(clr_p)
    );

    loader_state_t        state, state_n;
    logic [OPERAND_W-1:0] a_n, b_n;
    logic                 timeout;

`ifdef OPERAND_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_cnt;

    assign timeout = (state == WAIT_B) && (tmo_cnt >= TMO_MAX) && !load_p;

    // Runs only while staying in WAIT_B; entry and any load press restart it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (state == WAIT_B && state_n == WAIT_B && !load_p && tmo_cnt < TMO_MAX)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        a_n     = A;
        b_n     = B;
        if (clr_p) begin
            state_n = WAIT_A;
            a_n     = '0;
            b_n     = '0;
        end else if (load_p) begin
            case (state)
                WAIT_A: begin
                    a_n     = sw;
                    state_n = WAIT_B;
                end
                WAIT_B: begin
                    b_n     = sw;
                    state_n = SHOW;
                end
                default: begin
                    a_n     = '0;
                    b_n     = '0;
                    state_n = WAIT_A;
                end
            endcase
        end else if (timeout) begin
            state_n = WAIT_A;
            a_n     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WAIT_A;
            A         <= '0;
            B         <= '0;
            valid     <= 1'b0;
            state_led <= LED_WAIT_A;
        end else begin
            state     <= state_n;
            A         <= a_n;
            B         <= b_n;
            valid     <= (state_n == SHOW);
            state_led <= state_led_of(state_n);
        end
    end

    logic unused;
    assign unused = load_lvl ^ clr_lvl;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader with short debounce/timeout settings.
module tb_operand_loader;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw = '0;
    logic       btn_load = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] A, B;
    logic       valid;
    logic [1:0] state_led;

    int checks = 0;
    int failures = 0;

    operand_loader #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn_load(btn_load), .btn_clr(btn_clr),
        .A(A), .B(B), .valid(valid), .state_led(state_led)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                           input logic ev, input logic [1:0] el);
        chk({tag, ".A"}, {4'h0, A}, {4'h0, ea});
        chk({tag, ".B"}, {4'h0, B}, {4'h0, eb});
        chk({tag, ".valid"}, {7'h0, valid}, {7'h0, ev});
        chk({tag, ".led"}, {6'h0, state_led}, {6'h0, el});
    endtask

    task automatic press(input logic [3:0] v, input int hold);
        sw = v;
        btn_load = 1'b1;
        cyc(hold);
        btn_load = 1'b0;
        cyc(12);
    endtask

    initial begin
        cyc(1);
        rst = 1'b1;
        cyc(2);
        chk_all("reset", 4'h0, 4'h0, 1'b0, 2'b01);
        rst = 1'b0;
        cyc(2);

        // 1: two clean presses -> 15 + 10
        press(4'hF, 12);
        chk_all("t1_a", 4'hF, 4'h0, 1'b0, 2'b10);
        press(4'hA, 12);
        chk_all("t1_b", 4'hF, 4'hA, 1'b1, 2'b00);
        chk("t1_sum", 8'(A) + 8'(B), 8'd25);

        // load in SHOW starts a new entry
        sw = 4'h3;
        press(4'h3, 12);
        chk_all("show_load", 4'h0, 4'h0, 1'b0, 2'b01);

        // 2: bouncy press captures once
        sw = 4'h5;
        for (int i = 0; i < 5; i++) begin
            btn_load = ~btn_load;
            cyc(2);
        end
        btn_load = 1'b1;
        cyc(12);
        btn_load = 1'b0;
        cyc(12);
        chk_all("t2_bounce", 4'h5, 4'h0, 1'b0, 2'b10);

        // 3: long hold captures once
        btn_clr = 1'b1; cyc(12); btn_clr = 1'b0; cyc(12);
        chk_all("clr", 4'h0, 4'h0, 1'b0, 2'b01);
        press(4'h7, 40);
        chk_all("t3_hold", 4'h7, 4'h0, 1'b0, 2'b10);
        press(4'h5, 12);
        chk_all("t3_b", 4'h7, 4'h5, 1'b1, 2'b00);

        // 4: simultaneous load and clr in SHOW
        btn_clr = 1'b1; cyc(12); btn_clr = 1'b0; cyc(12);
        press(4'h1, 12);
        press(4'h2, 12);
        chk_all("t4_show", 4'h1, 4'h2, 1'b1, 2'b00);
        sw = 4'hE;
        btn_load = 1'b1; btn_clr = 1'b1;
        cyc(12);
        btn_load = 1'b0; btn_clr = 1'b0;
        cyc(12);
        chk_all("t4_both", 4'h0, 4'h0, 1'b0, 2'b01);

        // 5: reset mid-debounce in WAIT_B
        press(4'h9, 12);
        chk_all("t5_waitb", 4'h9, 4'h0, 1'b0, 2'b10);
        sw = 4'h6;
        btn_load = 1'b1;
        cyc(3);
        rst = 1'b1;
        #1;
        chk_all("t5_async", 4'h0, 4'h0, 1'b0, 2'b01);
        cyc(1);
        rst = 1'b0;
        btn_load = 1'b0;
        cyc(12);
        chk_all("t5_nocap", 4'h0, 4'h0, 1'b0, 2'b01);

        // 6: timeout behaviour in WAIT_B
        press(4'h3, 12);
        chk_all("t6_a", 4'h3, 4'h0, 1'b0, 2'b10);
        cyc(100);
`ifdef OPERAND_TIMEOUT_EN
        chk_all("t6_timeout", 4'h0, 4'h0, 1'b0, 2'b01);
`else
        chk_all("t6_wait", 4'h3, 4'h0, 1'b0, 2'b10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule
